tnnseq_feeder: RTL and testbench

TNNSEQ_FEEDER -- requirements
Module: tnnseq_feeder

---
 rtl/tnnseq_pkg.sv | 17 +
 rtl/tnnseq_feeder.sv | 110 +++++++++++
 tb/tb_tnnseq_feeder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tnnseq_pkg.sv
// Shared definitions for the sequential-classifier feeder.
// Holds the FSM encoding and default sizing.
package tnnseq_pkg;

  localparam int FEAT_CNT_DEF   = 128;
  localparam int HIDDEN_CNT_DEF = 40;
  localparam int FEAT_BITS_DEF  = 4;
  localparam int CLASS_CNT_DEF  = 6;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/tnnseq_feeder.sv
// Collects one sample of features, runs the classifier for a fixed
// number of cycles and holds its prediction until consumed.
module tnnseq_feeder
  import tnnseq_pkg::*;
#(
  parameter int FEAT_CNT   = FEAT_CNT_DEF,
  parameter int HIDDEN_CNT = HIDDEN_CNT_DEF,
  parameter int FEAT_BITS  = FEAT_BITS_DEF,
  parameter int CLASS_CNT  = CLASS_CNT_DEF,
  localparam int PRED_BITS = $clog2(CLASS_CNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FEAT_BITS-1:0]    feat_in,
  input  logic                    feat_valid,
  output logic                    feat_ready,
  input  logic                    clr,
  output logic [FEAT_BITS*FEAT_CNT-1:0] data,
  output logic                    tnn_rst,
  input  logic [PRED_BITS-1:0]    tnn_pred,
  output logic [PRED_BITS-1:0]    pred_out,
  output logic                    pred_valid,
  input  logic                    pred_ready,
  output logic                    busy
);

  localparam int IDX_W    = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int RUN_LAST = FEAT_CNT + HIDDEN_CNT;
  localparam int CNT_W    = $clog2(RUN_LAST + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LAST);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             beat_acc;
  logic             run_done;
  logic             pred_acc;

  assign feat_ready = (state == S_LOAD);
  assign tnn_rst    = (state != S_RUN);
  assign busy       = (state != S_LOAD);

  assign beat_acc = feat_valid && feat_ready && !clr;
  assign run_done = (state == S_RUN) && (cnt == CNT_LAST);
  assign pred_acc = (state == S_HOLD) && pred_valid && pred_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic; an abort always wins.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_LOAD;
    end else begin
      unique case (state)
        S_LOAD:
          if (beat_acc && idx == IDX_LAST)
            state_nxt = S_START;
        S_START:
          state_nxt = S_RUN;
        S_RUN:
          if (run_done) state_nxt = S_HOLD;
        S_HOLD:
          if (pred_acc) state_nxt = S_LOAD;
      endcase
    end
  end

  // Feature index and sample buffer; data is only written in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      data <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (beat_acc) begin
      data[int'(idx)*FEAT_BITS +: FEAT_BITS] <= feat_in;
      if (idx == IDX_LAST) idx <= '0;
      else                 idx <= idx + IDX_W'(1);
    end
  end

  // Run counter, prediction capture and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      pred_out   <= '0;
      pred_valid <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      pred_valid <= 1'b0;
    end else if (run_done) begin
      cnt        <= '0;
      pred_out   <= tnn_pred;
      pred_valid <= 1'b1;
    end else if (state == S_RUN) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pred_acc) begin
      pred_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tnnseq_feeder.sv
// Self-checking bench for tnnseq_feeder.
// Predictions are scoreboarded against a cycle-indexed stub classifier.
module tb_tnnseq_feeder;

  localparam int FC  = 128;
  localparam int HC  = 40;
  localparam int FB  = 4;
  localparam int CC  = 6;
  localparam int PB  = $clog2(CC);
  localparam int LAT = FC + HC + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [FB-1:0] feat_in = '0;
  logic feat_valid = 1'b0;
  logic feat_ready;
  logic clr = 1'b0;
  logic [FB*FC-1:0] data;
  logic tnn_rst;
  logic [PB-1:0] tnn_pred = '0;
  logic [PB-1:0] pred_out;
  logic pred_valid;
  logic pred_ready = 1'b0;
  logic busy;

  logic [FB*FC-1:0] exp_data = '0;
  logic [PB-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  tnnseq_feeder dut (
    .clk(clk),
    .rst(rst),
    .feat_in(feat_in),
    .feat_valid(feat_valid),
    .feat_ready(feat_ready),
    .clr(clr),
    .data(data),
    .tnn_rst(tnn_rst),
    .tnn_pred(tnn_pred),
    .pred_out(pred_out),
    .pred_valid(pred_valid),
    .pred_ready(pred_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub classifier: value sampled at edge M is (M-1) mod CC.
  always @(negedge clk) tnn_pred <= PB'(cyc % CC);

  task automatic feed(input int first, input int last,
                      input int mode, input bit push,
                      input bit keep);
    logic [FB-1:0] v;
    int n;
    for (int k = first; k <= last; k++) begin
      if (mode == 0) v = FB'(k);
      else v = FB'($urandom_range(0, 15));
      feat_valid = 1'b1;
      feat_in = v;
      n = 0;
      while (!feat_ready && n < 500) begin
        @(posedge clk); #1; n++;
      end
      if (!feat_ready) begin
        total++; bad++;
        $display("FAIL feed_ready beat=%0d got=%b want=1",
                 k, feat_ready);
      end
      @(posedge clk); #1;
      exp_data[k*FB +: FB] = v;
    end
    if (!keep) feat_valid = 1'b0;
    if (push) exp_q.push_back(PB'((cyc + LAT - 1) % CC));
  endtask

  task automatic wait_pred();
    int n;
    int low;
    logic [PB-1:0] e;
    n = 0;
    low = 0;
    while (!pred_valid && n < LAT + 50) begin
      @(posedge clk); #1; n++;
      if (!tnn_rst) low++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("FAIL latency got=%0d want=%0d", n, LAT);
    end
    total++;
    if (low !== LAT - 1) begin
      bad++;
      $display("FAIL tnn_rst_low got=%0d want=%0d", low, LAT - 1);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total++;
    if (pred_out !== e) begin
      bad++;
      $display("FAIL pred_out got=%0d want=%0d", pred_out, e);
    end
  endtask

  task automatic check_data(input string tag);
    total++;
    if (data !== exp_data) begin
      bad++;
      $display("FAIL data_%s got=%h want=%h", tag, data, exp_data);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if ({feat_ready, tnn_rst, busy, pred_valid} !== 4'b1100) begin
      bad++;
      $display("FAIL %s_ctl got=%b want=1100", tag,
               {feat_ready, tnn_rst, busy, pred_valid});
    end
    total++;
    if (data !== '0) begin
      bad++;
      $display("FAIL %s_data got=%h want=0", tag, data);
    end
    total++;
    if (pred_out !== '0) begin
      bad++;
      $display("FAIL %s_pred got=%0d want=0", tag, pred_out);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    exp_data = '0;
  endtask

  task automatic test_full();
    feed(0, FC - 1, 0, 1, 0);
    check_data("full");
    wait_pred();
  endtask

  task automatic test_hold();
    logic [PB-1:0] held;
    int errs;
    held = pred_out;
    errs = 0;
    feat_valid = 1'b1;
    feat_in = 4'hF;
    repeat (20) begin
      @(posedge clk); #1;
      if (pred_valid !== 1'b1 || pred_out !== held ||
          feat_ready !== 1'b0 || tnn_rst !== 1'b1)
        errs++;
    end
    feat_valid = 1'b0;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL hold_stable got=%0d bad cycles want=0", errs);
    end
    check_data("hold");
    pred_ready = 1'b1;
    @(posedge clk); #1;
    pred_ready = 1'b0;
    total++;
    if ({pred_valid, feat_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL hold_release got=%b want=010",
               {pred_valid, feat_ready, busy});
    end
  endtask

  task automatic test_clr_load();
    feed(0, 49, 1, 0, 0);
    feat_valid = 1'b1;
    feat_in = 4'hA;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    feat_valid = 1'b0;
    total++;
    if ({busy, feat_ready} !== 2'b01) begin
      bad++;
      $display("FAIL clr_load_state got=%b want=01",
               {busy, feat_ready});
    end
    check_data("clr_keep");
    feed(0, 0, 1, 0, 0);
    total++;
    if (data[FB-1:0] !== exp_data[FB-1:0] || data !== exp_data) begin
      bad++;
      $display("FAIL clr_nib0 got=%h want=%h",
               data[FB-1:0], exp_data[FB-1:0]);
    end
    feed(1, FC - 1, 1, 1, 0);
    check_data("clr_refill");
    wait_pred();
    pred_ready = 1'b1;
    @(posedge clk); #1;
    pred_ready = 1'b0;
  endtask

  task automatic test_clr_run();
    bit seen;
    feed(0, FC - 1, 2, 0, 0);
    repeat (101) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if ({busy, tnn_rst, pred_valid} !== 3'b010) begin
      bad++;
      $display("FAIL clr_run_state got=%b want=010",
               {busy, tnn_rst, pred_valid});
    end
    check_data("clr_run_keep");
    seen = 1'b0;
    repeat (LAT + 30) begin
      @(posedge clk); #1;
      if (pred_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL clr_run_pred got=%b want=0", seen);
    end
  endtask

  task automatic test_rst_run();
    feed(0, FC - 1, 2, 0, 0);
    repeat (32) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_reset_vals("rst_run");
    exp_data = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    feed(0, FC - 1, 2, 1, 0);
    check_data("rst_refill");
    wait_pred();
    pred_ready = 1'b1;
    @(posedge clk); #1;
    pred_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    pred_ready = 1'b1;
    feed(0, FC - 1, 2, 1, 1);
    check_data("b2b_a");
    wait_pred();
    @(posedge clk); #1;
    total++;
    if ({feat_ready, pred_valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_ready got=%b want=10",
               {feat_ready, pred_valid});
    end
    feed(0, FC - 1, 2, 1, 1);
    check_data("b2b_b");
    wait_pred();
    feat_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got=%b want=0", busy);
    end
    pred_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full();
    test_hold();
    test_clr_load();
    test_clr_run();
    test_rst_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
